// File: rtl/bit_nco_dpll.sv
// Bit-timing NCO with a second-order DPLL that tracks clock or data
// transitions around the frequency estimator's initial word.
module bit_nco_dpll #(
  parameter int KP_SHIFT    = 4,
  parameter int KI_SHIFT    = 10,
  parameter int NARROW_ADD  = 2,
  parameter int RANGE_SHIFT = 6,
  parameter int LOCK_CNT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] freq_init,
  input  logic        load_init,
  input  logic        track_en,
  input  logic        track_data,
  input  logic        transition,
  input  logic        transition_data,
  output logic        bit_strobe,
  output logic [31:0] phase,
  output logic [31:0] freq,
  output logic        lock,
  output logic        lock_err,
  output logic        outside_freq_range
);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } state_t;

  state_t state_q, state_d;

  logic [31:0]        lo_q, hi_q;
  logic signed [31:0] err_q;
  logic               err_valid_q;
  logic [7:0]         good_cnt_q;

  logic               sel, run;
  logic               good, bad;
  logic [4:0]         kp, ki;
  logic signed [31:0] p_term, i_term, corr;
  logic signed [33:0] acc_sum, int_sum;
  logic signed [32:0] err_ext;
  logic [32:0]        err_mag;
  logic [31:0]        dev;
  logic [32:0]        hi_raw;

  assign sel = track_data ? transition_data : transition;
  assign run = (state_q != IDLE);

  assign p_term = err_q >>> kp;
  assign i_term = err_q >>> ki;
  assign corr   = err_valid_q ? -p_term : '0;

  assign acc_sum = $signed({2'b00, phase})
                 + $signed({2'b00, freq})
                 + 34'(corr);
  assign int_sum = $signed({2'b00, freq})
                 - 34'(i_term);

  // 33-bit magnitude so that err = -2^31 reads as 2^31
  assign err_ext = 33'(err_q);
  assign err_mag = err_q[31] ? 33'(-err_ext) : 33'(err_ext);
  assign good    = err_mag < 33'h0_0800_0000;
  assign bad     = err_mag >= 33'h0_4000_0000;

  assign dev    = freq_init >> RANGE_SHIFT;
  assign hi_raw = {1'b0, freq_init} + {1'b0, dev};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!track_en) begin
      state_d = IDLE;
    end else if (load_init) begin
      state_d = ACQUIRE;
    end else begin
      unique case (1'b1)
        (state_q == ACQUIRE):
          if (err_valid_q && good &&
              good_cnt_q == 8'(LOCK_CNT - 1))
            state_d = LOCKED;
        (state_q == LOCKED):
          if (err_valid_q && bad)
            state_d = ACQUIRE;
        default: ;
      endcase
    end
  end

  always_comb begin
    kp = 5'(KP_SHIFT);
    ki = 5'(KI_SHIFT);
    if (state_q == LOCKED) begin
      kp = 5'(KP_SHIFT + NARROW_ADD);
      ki = 5'(KI_SHIFT + NARROW_ADD);
    end
  end

  assign lock = (state_q == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase              <= '0;
      freq               <= '0;
      bit_strobe         <= 1'b0;
      lock_err           <= 1'b0;
      outside_freq_range <= 1'b0;
      lo_q               <= '0;
      hi_q               <= '0;
      err_q              <= '0;
      err_valid_q        <= 1'b0;
      good_cnt_q         <= '0;
    end else if (!track_en) begin
      bit_strobe  <= 1'b0;
      lock_err    <= 1'b0;
      err_valid_q <= 1'b0;
    end else if (load_init) begin
      phase              <= '0;
      freq               <= freq_init;
      // dev never exceeds freq_init, so the low bound cannot underflow
      lo_q               <= freq_init - dev;
      hi_q               <= hi_raw[32] ? '1 : hi_raw[31:0];
      outside_freq_range <= 1'b0;
      good_cnt_q         <= '0;
      err_valid_q        <= 1'b0;
      bit_strobe         <= 1'b0;
      lock_err           <= 1'b0;
    end else if (!run) begin
      bit_strobe  <= 1'b0;
      lock_err    <= 1'b0;
      err_valid_q <= 1'b0;
    end else begin
      phase       <= acc_sum[31:0];
      bit_strobe  <= (acc_sum[33:32] == 2'b01);
      err_valid_q <= sel;
      lock_err    <= 1'b0;
      if (sel)
        err_q <= $signed(phase);
      if (err_valid_q) begin
        if (int_sum < $signed({2'b00, lo_q})) begin
          freq               <= lo_q;
          outside_freq_range <= 1'b1;
        end else if (int_sum > $signed({2'b00, hi_q})) begin
          freq               <= hi_q;
          outside_freq_range <= 1'b1;
        end else begin
          freq <= int_sum[31:0];
        end
        if (state_q == ACQUIRE) begin
          good_cnt_q <= good ? good_cnt_q + 8'd1 : '0;
        end else if (bad) begin
          good_cnt_q <= '0;
          lock_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_nco_dpll.sv
// Bench for bit_nco_dpll: directed scenarios plus randomized traffic
// checked every cycle against an arithmetic loop model.
module tb_bit_nco_dpll;

  localparam int KP = 4;
  localparam int KI = 10;
  localparam int NA = 2;
  localparam int RS = 6;
  localparam int LC = 64;
  localparam longint TWO32 = 64'h1_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] freq_init;
  logic        load_init;
  logic        track_en;
  logic        track_data;
  logic        transition;
  logic        transition_data;
  logic        bit_strobe;
  logic [31:0] phase;
  logic [31:0] freq;
  logic        lock;
  logic        lock_err;
  logic        outside_freq_range;

  always #5 clk = ~clk;

  bit_nco_dpll #(
    .KP_SHIFT   (KP),
    .KI_SHIFT   (KI),
    .NARROW_ADD (NA),
    .RANGE_SHIFT(RS),
    .LOCK_CNT   (LC)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .freq_init         (freq_init),
    .load_init         (load_init),
    .track_en          (track_en),
    .track_data        (track_data),
    .transition        (transition),
    .transition_data   (transition_data),
    .bit_strobe        (bit_strobe),
    .phase             (phase),
    .freq              (freq),
    .lock              (lock),
    .lock_err          (lock_err),
    .outside_freq_range(outside_freq_range)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: 0 idle, 1 acquiring, 2 locked
  int     m_st;
  int     m_cnt;
  longint m_phase, m_freq, m_lo, m_hi, m_err;
  bit     m_ev, m_strobe, m_lerr, m_oor;

  function automatic longint fdiv(input longint a, input int k);
    longint d;
    d = longint'(1) << k;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic longint as_signed(input longint x);
    return (x >= TWO32 / 2) ? x - TWO32 : x;
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0;
    m_phase = 0; m_freq = 0; m_lo = 0; m_hi = 0; m_err = 0;
    m_ev = 0; m_strobe = 0; m_lerr = 0; m_oor = 0;
  endtask

  task automatic model_step();
    longint s, f, mag;
    int nw;
    bit ev_now;
    ev_now = track_data ? transition_data : transition;
    if (rst) begin
      model_reset();
    end else if (!track_en) begin
      m_st = 0; m_strobe = 0; m_lerr = 0; m_ev = 0;
    end else if (load_init) begin
      m_phase = 0;
      m_freq  = longint'(freq_init);
      m_lo    = longint'(freq_init) - longint'(freq_init >> RS);
      m_hi    = longint'(freq_init) + longint'(freq_init >> RS);
      if (m_hi > TWO32 - 1) m_hi = TWO32 - 1;
      m_oor = 0; m_cnt = 0; m_ev = 0;
      m_strobe = 0; m_lerr = 0; m_st = 1;
    end else if (m_st == 0) begin
      m_strobe = 0; m_lerr = 0; m_ev = 0;
    end else begin
      nw = (m_st == 2) ? NA : 0;
      s = m_phase + m_freq;
      m_lerr = 0;
      if (m_ev) begin
        s = s - fdiv(m_err, KP + nw);
        f = m_freq - fdiv(m_err, KI + nw);
        if (f < m_lo) begin
          f = m_lo; m_oor = 1;
        end else if (f > m_hi) begin
          f = m_hi; m_oor = 1;
        end
        m_freq = f;
        mag = (m_err < 0) ? -m_err : m_err;
        if (m_st == 1) begin
          if (mag < (longint'(1) << 27)) begin
            m_cnt++;
            if (m_cnt == LC) m_st = 2;
          end else begin
            m_cnt = 0;
          end
        end else if (mag >= (longint'(1) << 30)) begin
          m_st = 1; m_cnt = 0; m_lerr = 1;
        end
      end
      m_strobe = (s >= TWO32);
      if (ev_now) m_err = as_signed(m_phase);
      m_ev = ev_now;
      m_phase = ((s % TWO32) + TWO32) % TWO32;
    end
  endtask

  function automatic logic [67:0] obs_vec();
    return {phase, freq, bit_strobe, lock, lock_err, outside_freq_range};
  endfunction

  function automatic logic [67:0] exp_vec();
    logic [31:0] p, f;
    p = m_phase[31:0];
    f = m_freq[31:0];
    return {p, f, m_strobe, (m_st == 2), m_lerr, m_oor};
  endfunction

  task automatic check(input string tag,
                       input logic [67:0] obs,
                       input logic [67:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("cycle", obs_vec(), exp_vec());
  endtask

  task automatic clear_events();
    load_init = 1'b0;
    transition = 1'b0;
    transition_data = 1'b0;
  endtask

  task automatic acquire_clock(input int n);
    freq_init = 32'h1000_0000;
    track_en = 1'b1;
    track_data = 1'b0;
    load_init = 1'b1;
    cycle();
    load_init = 1'b0;
    for (int i = 0; i < n; i++) begin
      transition = m_strobe;
      cycle();
    end
    transition = 1'b0;
  endtask

  initial begin
    logic [31:0] f0, f1;
    bit found, seen;
    rst = 1'b1;
    track_en = 1'b0;
    track_data = 1'b0;
    freq_init = '0;
    clear_events();
    model_reset();

    #12;
    check("reset_state", obs_vec(), 68'd0);
    @(negedge clk);
    rst = 1'b0;

    // free run: one strobe every 16 clocks
    track_en = 1'b1;
    freq_init = 32'h1000_0000;
    load_init = 1'b1;
    cycle();
    load_init = 1'b0;
    for (int i = 1; i <= 48; i++) begin
      cycle();
      check("free_strobe", 68'(bit_strobe), 68'(i % 16 == 0));
    end
    check("free_freq", 68'(freq), 68'(32'h1000_0000));
    check("free_lock", 68'(lock), 68'd0);

    // acquire on clock transitions aligned with the wrap
    for (int i = 0; i < 1100; i++) begin
      transition = m_strobe;
      cycle();
    end
    transition = 1'b0;
    check("acq_lock", 68'(lock), 68'd1);
    check("acq_freq_rng",
          68'(freq >= 32'h0FC0_0000 && freq <= 32'h1040_0000), 68'd1);
    check("acq_oor", 68'(outside_freq_range), 68'd0);

    // loss of lock from one transition at phase 0x60000000
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_phase == 64'h6000_0000) found = 1'b1;
      else cycle();
    end
    check("lol_found", 68'(found), 68'd1);
    transition = 1'b1;
    cycle();
    transition = 1'b0;
    check("lol_n0_err", 68'(lock_err), 68'd0);
    check("lol_n0_lock", 68'(lock), 68'd1);
    cycle();
    check("lol_n1_err", 68'(lock_err), 68'd1);
    check("lol_n1_lock", 68'(lock), 68'd0);
    cycle();
    check("lol_n2_err", 68'(lock_err), 68'd0);

    // data transitions every 15 clocks push freq into the high clamp
    freq_init = 32'h1000_0000;
    track_data = 1'b1;
    load_init = 1'b1;
    cycle();
    load_init = 1'b0;
    seen = 1'b0;
    for (int i = 1; i <= 3000; i++) begin
      transition_data = (i % 15 == 0);
      cycle();
      if (m_oor && !seen) begin
        seen = 1'b1;
        check("clamp_hi", 68'(freq), 68'(32'h1040_0000));
      end
    end
    transition_data = 1'b0;
    check("oor_sticky", 68'(outside_freq_range), 68'd1);

    // load beats a coincident transition
    f0 = 32'h0C00_0000 | ($urandom & 32'h03FF_FFFF);
    freq_init = f0;
    track_data = 1'b0;
    transition = 1'b1;
    load_init = 1'b1;
    cycle();
    clear_events();
    check("prio_ld_freq", 68'(freq), 68'(f0));
    check("prio_ld_phase", 68'(phase), 68'd0);
    check("prio_ld_oor", 68'(outside_freq_range), 68'd0);
    cycle();
    check("prio_no_corr", 68'(phase), 68'(f0));

    // track_en low beats load_init
    f1 = f0 ^ 32'h0100_0000;
    freq_init = f1;
    track_en = 1'b0;
    load_init = 1'b1;
    cycle();
    load_init = 1'b0;
    track_en = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check("prio_en_freq", 68'(freq), 68'(f0));
    check("prio_en_phase", 68'(phase), 68'(f0));
    check("prio_en_strobe", 68'(bit_strobe), 68'd0);
    check("prio_en_lock", 68'(lock), 68'd0);

    // randomized traffic against the model
    for (int r = 0; r < 4; r++) begin
      track_en = 1'b1;
      freq_init = 32'h0800_0000 + $urandom_range(0, 32'h1800_0000);
      load_init = 1'b1;
      cycle();
      load_init = 1'b0;
      track_data = 1'($urandom_range(0, 1));
      for (int i = 0; i < 700; i++) begin
        transition = (m_strobe && $urandom_range(0, 3) != 0) ||
                     ($urandom_range(0, 99) < 2);
        transition_data = (m_strobe && $urandom_range(0, 3) != 0) ||
                          ($urandom_range(0, 99) < 2);
        load_init = ($urandom_range(0, 999) == 0);
        track_en = ($urandom_range(0, 499) != 0);
        cycle();
      end
      clear_events();
    end

    // asynchronous reset between clock edges while locked
    acquire_clock(1100);
    check("pre_rst_lock", 68'(lock), 68'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", obs_vec(), 68'd0);
    model_reset();
    @(negedge clk);
    check("rst_hold", obs_vec(), 68'd0);
    rst = 1'b0;
    cycle();
    check("post_rst_lock", 68'(lock), 68'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
